// File: rtl/wb_stage_pkg.sv
// Shared writeback-select encodings and load funct3 codes for the RV32I core;
// the decoder imports the same definitions.
package wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_IMM = 2'b11
   } wbsel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load extraction: picks byte/halfword/word from an aligned
// memory word by address offset and sign- or zero-extends it to 32 bits.
module load_extend
   import wb_stage_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed byte and halfword lanes.
   always_comb begin
      byte_sel = word[7:0];
      half_sel = word[15:0];
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         2'd3:    byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      // Halfword loads ignore offset bit 0; misalignment is not trapped here.
      if (offset[1]) begin
         half_sel = word[31:16];
      end else begin
         half_sel = word[15:0];
      end
   end

   // Extend according to the load width and signedness.
   always_comb begin
      value = word;
      case (funct3)
         F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  value = {24'h000000, byte_sel};
         F3_LH:   value = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  value = {16'h0000, half_sel};
         F3_LW:   value = word;
         default: value = word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback selector and retired-instruction counter.
// Optional register-file write-through bypass when WB_BYPASS_EN is defined.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic            RegWrite_in,
   input  logic [1:0]      WBSel_in,
   input  logic [2:0]      Funct3_in,
   input  logic [4:0]      Rd_in,
   input  logic [XLEN-1:0] ALUResult_in,
   input  logic [XLEN-1:0] MemData_in,
   input  logic [XLEN-1:0] PC_in,
   input  logic [XLEN-1:0] Imm_in,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] RD1_in,
   input  logic [XLEN-1:0] RD2_in,
   output logic [XLEN-1:0] RD1_out,
   output logic [XLEN-1:0] RD2_out,
   output logic            RegWrite,
   output logic [4:0]      WA,
   output logic [XLEN-1:0] WD,
   output logic            wb_valid,
   output logic [63:0]     instret
);

   logic [XLEN-1:0] stage_alu;
   logic [XLEN-1:0] stage_mem;
   logic [XLEN-1:0] stage_pc;
   logic [XLEN-1:0] stage_imm;
   wbsel_t          stage_sel;
   logic [2:0]      stage_funct3;
   logic [XLEN-1:0] load_value;

   // Stage register: reset, then flush (bubble), then stall (hold), then load.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid     <= 1'b0;
         RegWrite     <= 1'b0;
         WA           <= 5'd0;
         stage_alu    <= 32'h00000000;
         stage_mem    <= 32'h00000000;
         stage_pc     <= 32'h00000000;
         stage_imm    <= 32'h00000000;
         stage_sel    <= WB_ALU;
         stage_funct3 <= 3'b000;
         instret      <= 64'd0;
      end else if (flush) begin
         // Data fields are left stale; only the valid/write qualifiers drop.
         wb_valid <= 1'b0;
         RegWrite <= 1'b0;
      end else if (!stall) begin
         wb_valid     <= in_valid;
         RegWrite     <= in_valid & RegWrite_in & (Rd_in != 5'd0);
         WA           <= Rd_in;
         stage_alu    <= ALUResult_in;
         stage_mem    <= MemData_in;
         stage_pc     <= PC_in;
         stage_imm    <= Imm_in;
         stage_sel    <= wbsel_t'(WBSel_in);
         stage_funct3 <= Funct3_in;
         if (in_valid) begin
            instret <= instret + 64'd1;
         end
      end
   end

   load_extend u_load_extend (
      .word   (stage_mem),
      .offset (stage_alu[1:0]),
      .funct3 (stage_funct3),
      .value  (load_value)
   );

   // Writeback value mux over the registered fields.
   always_comb begin
      WD = stage_alu;
      case (stage_sel)
         WB_ALU:  WD = stage_alu;
         WB_MEM:  WD = load_value;
         WB_PC4:  WD = stage_pc + 32'd4;
         WB_IMM:  WD = stage_imm;
         default: WD = stage_alu;
      endcase
   end

`ifdef WB_BYPASS_EN
   // Write-through: a read of the register being written this cycle sees WD.
   always_comb begin
      RD1_out = RD1_in;
      RD2_out = RD2_in;
      if (RegWrite && (WA == rs1_addr) && (rs1_addr != 5'd0)) begin
         RD1_out = WD;
      end else begin
         RD1_out = RD1_in;
      end
      if (RegWrite && (WA == rs2_addr) && (rs2_addr != 5'd0)) begin
         RD2_out = WD;
      end else begin
         RD2_out = RD2_in;
      end
   end
`else
   logic unused_read_addr;

   assign unused_read_addr = ^{rs1_addr, rs2_addr};
   assign RD1_out          = RD1_in;
   assign RD2_out          = RD2_in;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a behavioural model. Honours WB_BYPASS_EN when defined.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, RegWrite_in;
   logic [1:0]  WBSel_in;
   logic [2:0]  Funct3_in;
   logic [4:0]  Rd_in, rs1_addr, rs2_addr;
   logic [31:0] ALUResult_in, MemData_in, PC_in, Imm_in, RD1_in, RD2_in;
   logic [31:0] RD1_out, RD2_out, WD;
   logic        RegWrite, wb_valid;
   logic [4:0]  WA;
   logic [63:0] instret;

   int checks = 0;
   int errors = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .RegWrite_in(RegWrite_in), .WBSel_in(WBSel_in), .Funct3_in(Funct3_in),
      .Rd_in(Rd_in), .ALUResult_in(ALUResult_in), .MemData_in(MemData_in),
      .PC_in(PC_in), .Imm_in(Imm_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .RD1_in(RD1_in), .RD2_in(RD2_in), .RD1_out(RD1_out), .RD2_out(RD2_out),
      .RegWrite(RegWrite), .WA(WA), .WD(WD), .wb_valid(wb_valid), .instret(instret)
   );

   // Reference model state (m_known: WA/WD are defined, i.e. not stale after flush)
   logic        m_valid, m_rw, m_known;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic [63:0] m_instret;

   function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [2:0] f3,
                                          input logic [31:0] alu, input logic [31:0] mem,
                                          input logic [31:0] pc, input logic [31:0] imm);
      int unsigned off, b, h;
      if (sel == 2'd0) return alu;
      if (sel == 2'd2) return pc + 32'd4;
      if (sel == 2'd3) return imm;
      off = alu % 4;
      b = (mem >> (8 * off)) % 256;
      h = (mem >> (16 * (off / 2))) % 65536;
      if (f3 == 3'd0) return (b >= 128) ? b - 256 : b;
      if (f3 == 3'd4) return b;
      if (f3 == 3'd1) return (h >= 32768) ? h - 65536 : h;
      if (f3 == 3'd5) return h;
      return mem;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0; m_rw <= 1'b0; m_wa <= 5'd0; m_wd <= 32'd0;
         m_known <= 1'b1; m_instret <= 64'd0;
      end else if (flush) begin
         m_valid <= 1'b0; m_rw <= 1'b0; m_known <= 1'b0;
      end else if (!stall) begin
         m_valid <= in_valid;
         m_rw    <= in_valid && RegWrite_in && (Rd_in != 5'd0);
         m_wa    <= Rd_in;
         m_wd    <= ref_wd(WBSel_in, Funct3_in, ALUResult_in, MemData_in, PC_in, Imm_in);
         m_known <= 1'b1;
         if (in_valid) m_instret <= m_instret + 64'd1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input logic v, input logic rw, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] mem,
                           input logic [31:0] pc, input logic [31:0] imm);
      in_valid = v; RegWrite_in = rw; WBSel_in = sel; Funct3_in = f3; Rd_in = rd;
      ALUResult_in = alu; MemData_in = mem; PC_in = pc; Imm_in = imm;
   endtask

   task automatic test_reset;
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      set_inst(1'b1, 1'b1, 2'b11, 3'b010, 5'd3, 32'h11111111, 32'h22222222,
               32'h33333333, 32'h44444444);
      rs1_addr = 5'd0; rs2_addr = 5'd0; RD1_in = 32'd0; RD2_in = 32'd0;
      tick; tick;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
      checks++; if (WA !== 5'd0) begin errors++; $display("FAIL reset_wa: got %0d expected 0", WA); end
      checks++; if (WD !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h expected 0", WD); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
      checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
      rst = 1'b0; in_valid = 1'b0;
      tick;
      checks++; if (instret !== 64'd0) begin errors++; $display("FAIL release_instret: got %0d expected 0", instret); end
   endtask

   task automatic test_select;
      set_inst(1'b1, 1'b1, 2'b00, 3'b010, 5'd5, 32'h00001234, 32'h0, 32'h0, 32'h0);
      tick;
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL sel_alu_rw: got %b expected 1", RegWrite); end
      checks++; if (WA !== 5'd5) begin errors++; $display("FAIL sel_alu_wa: got %0d expected 5", WA); end
      checks++; if (WD !== 32'h00001234) begin errors++; $display("FAIL sel_alu_wd: got %h expected 00001234", WD); end
      checks++; if (instret !== 64'd1) begin errors++; $display("FAIL sel_instret: got %0d expected 1", instret); end
      set_inst(1'b1, 1'b1, 2'b10, 3'b010, 5'd1, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0);
      tick;
      checks++; if (WD !== 32'h00000000) begin errors++; $display("FAIL sel_pc4_wrap: got %h expected 00000000", WD); end
      set_inst(1'b1, 1'b1, 2'b11, 3'b010, 5'd2, 32'h0, 32'h0, 32'h0, 32'hABCDE000);
      tick;
      checks++; if (WD !== 32'hABCDE000) begin errors++; $display("FAIL sel_imm: got %h expected abcde000", WD); end
   endtask

   task automatic test_loads;
      logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [1:0]  offs[4] = '{2'd3, 2'd1, 2'd2, 2'd3};
      logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h000080FF};
      for (int i = 0; i < 4; i++) begin
         set_inst(1'b1, 1'b1, 2'b01, f3s[i], 5'd10, {30'h400, offs[i]}, 32'h80FF7F01, 32'h0, 32'h0);
         tick;
         checks++;
         if (WD !== exps[i]) begin
            errors++; $display("FAIL load_%0d: got %h expected %h", i, WD, exps[i]);
         end
      end
      set_inst(1'b1, 1'b1, 2'b01, 3'b010, 5'd10, 32'h00000002, 32'h80FF7F01, 32'h0, 32'h0);
      tick;
      checks++; if (WD !== 32'h80FF7F01) begin errors++; $display("FAIL load_lw: got %h expected 80ff7f01", WD); end
   endtask

   task automatic test_x0;
      set_inst(1'b1, 1'b1, 2'b00, 3'b010, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
      tick;
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite: got %b expected 0", RegWrite); end
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %b expected 1", wb_valid); end
      rs1_addr = 5'd0; RD1_in = 32'h00000055;
      #1;
      checks++; if (RD1_out !== 32'h00000055) begin errors++; $display("FAIL x0_bypass: got %h expected 00000055", RD1_out); end
   endtask

   task automatic test_stall_flush;
      logic [63:0] snap;
      set_inst(1'b1, 1'b1, 2'b00, 3'b010, 5'd9, 32'h0000ABCD, 32'h0, 32'h0, 32'h0);
      tick;
      snap = m_instret;
      stall = 1'b1;
      set_inst(1'b1, 1'b1, 2'b11, 3'b010, 5'd12, 32'h0, 32'h0, 32'h0, 32'h99999999);
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (RegWrite !== 1'b1 || WA !== 5'd9 || WD !== 32'h0000ABCD || instret !== snap) begin
            errors++;
            $display("FAIL stall_hold_%0d: got rw=%b wa=%0d wd=%h ir=%0d expected rw=1 wa=9 wd=0000abcd ir=%0d",
                     i, RegWrite, WA, WD, instret, snap);
         end
      end
      flush = 1'b1;
      tick;
      checks++;
      if (wb_valid !== 1'b0 || RegWrite !== 1'b0 || instret !== snap) begin
         errors++;
         $display("FAIL stall_flush: got v=%b rw=%b ir=%0d expected v=0 rw=0 ir=%0d", wb_valid, RegWrite, instret, snap);
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_bypass;
      logic [31:0] exp2;
      set_inst(1'b1, 1'b1, 2'b11, 3'b010, 5'd7, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);
      tick;
      rs2_addr = 5'd7; RD2_in = 32'h00000000; rs1_addr = 5'd8; RD1_in = 32'h12345678;
      #1;
      exp2 = BYP ? 32'hDEADBEEF : 32'h00000000;
      checks++; if (RD2_out !== exp2) begin errors++; $display("FAIL bypass_rd2: got %h expected %h", RD2_out, exp2); end
      checks++; if (RD1_out !== 32'h12345678) begin errors++; $display("FAIL bypass_rd1_miss: got %h expected 12345678", RD1_out); end
   endtask

   task automatic test_random;
      logic [31:0] e1, e2;
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 9) == 0);
         stall = ($urandom_range(0, 5) == 0);
         set_inst($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, $urandom);
         tick;
         rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
         RD1_in = $urandom; RD2_in = $urandom;
         #1;
         e1 = (BYP && m_rw && m_wa == rs1_addr && rs1_addr != 5'd0) ? m_wd : RD1_in;
         e2 = (BYP && m_rw && m_wa == rs2_addr && rs2_addr != 5'd0) ? m_wd : RD2_in;
         checks++;
         if (wb_valid !== m_valid || RegWrite !== m_rw || instret !== m_instret) begin
            errors++;
            $display("FAIL rand_ctrl_%0d: got v=%b rw=%b ir=%0d expected v=%b rw=%b ir=%0d",
                     n, wb_valid, RegWrite, instret, m_valid, m_rw, m_instret);
         end
         if (m_known) begin
            checks++;
            if (WA !== m_wa || WD !== m_wd) begin
               errors++;
               $display("FAIL rand_data_%0d: got wa=%0d wd=%h expected wa=%0d wd=%h", n, WA, WD, m_wa, m_wd);
            end
         end
         checks++;
         if (RD1_out !== e1 || RD2_out !== e2) begin
            errors++;
            $display("FAIL rand_read_%0d: got %h/%h expected %h/%h", n, RD1_out, RD2_out, e1, e2);
         end
      end
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset;
      test_select;
      test_loads;
      test_x0;
      test_stall_flush;
      test_bypass;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
